interleaver_stream: RTL and testbench

Parametrised IEEE 802.11a/g block interleaver/deinterleaver with ping-pong buffering and full-throughput AXI-Stream operation. One OFDM symbol's coded bits (48/96/192/288, selected by rate) are collected into one bank while the other bank drains, permuted, on the master side. The block sits between the convolutional encoder/puncturer and the mapper on TX (DIRECTION=0). It sits between the demapper and the depuncturer on RX (DIRECTION=1).

---
 rtl/interleaver_stream_pkg.sv | 68 ++++++
 rtl/interleaver_bank.sv | 58 +++++
 rtl/interleaver_stream.sv | 145 ++++++++++++++
 tb/tb_interleaver_stream.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interleaver_stream_pkg.sv
// 802.11a/g interleaver definitions: RATE field codes, coded bits per symbol
// and the forward/inverse permutations, evaluated only at elaboration time.
package interleaver_stream_pkg;

  localparam logic [3:0] RATE_6M  = 4'hD;
  localparam logic [3:0] RATE_9M  = 4'hF;
  localparam logic [3:0] RATE_12M = 4'h5;
  localparam logic [3:0] RATE_18M = 4'h7;
  localparam logic [3:0] RATE_24M = 4'h9;
  localparam logic [3:0] RATE_36M = 4'hB;
  localparam logic [3:0] RATE_48M = 4'h1;
  localparam logic [3:0] RATE_54M = 4'h3;

  localparam int CBPS_BPSK  = 48;
  localparam int CBPS_QPSK  = 96;
  localparam int CBPS_QAM16 = 192;
  localparam int CBPS_QAM64 = 288;
  localparam int CBPS_MAX   = 288;
  localparam int CNT_W      = 9;

  typedef enum logic [1:0] {
    CLS_BPSK  = 2'd0,
    CLS_QPSK  = 2'd1,
    CLS_QAM16 = 2'd2,
    CLS_QAM64 = 2'd3
  } rate_class_e;

  // Unknown codes fall back to the 48-bit BPSK block.
  function automatic rate_class_e rate_class(input logic [3:0] rate);
    case (rate)
      RATE_12M, RATE_18M: return CLS_QPSK;
      RATE_24M, RATE_36M: return CLS_QAM16;
      RATE_48M, RATE_54M: return CLS_QAM64;
      RATE_6M,  RATE_9M:  return CLS_BPSK;
      default:            return CLS_BPSK;
    endcase
  endfunction

  function automatic int cbps_of_class(input int cls);
    case (cls)
      1:       return CBPS_QPSK;
      2:       return CBPS_QAM16;
      3:       return CBPS_QAM64;
      default: return CBPS_BPSK;
    endcase
  endfunction

  // Position j that coded bit k occupies after both 802.11 permutation steps.
  function automatic int perm_fwd(input int k, input int n_cbps);
    int n_bpsc;
    int s;
    int i;
    n_bpsc = n_cbps / 48;
    s      = (n_bpsc / 2 > 1) ? n_bpsc / 2 : 1;
    i      = (n_cbps / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + n_cbps - (16 * i) / n_cbps) % s;
  endfunction

  function automatic int perm_inv(input int j, input int n_cbps);
    int k_found;
    k_found = 0;
    for (int k = 0; k < n_cbps; k++) begin
      if (perm_fwd(k, n_cbps) == j) k_found = k;
    end
    return k_found;
  endfunction

endpackage

// File: rtl/interleaver_bank.sv
// One ping-pong bank: 288 bits written a beat at a time, the block's rate
// latched on beat 0, and a full flag owned jointly by the write and read sides.
module interleaver_bank
  import interleaver_stream_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                wr_en,
  input  logic [CNT_W-1:0]    wr_beat,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [3:0]          wr_rate,
  input  logic                set_full,
  input  logic                clr_full,
  output logic [CBPS_MAX-1:0] bits,
  output logic [3:0]          rate,
  output logic                full
);

  localparam int NB_MAX = CBPS_MAX / DATA_W;

  logic [CBPS_MAX-1:0] bits_q, bits_d;
  logic [3:0]          rate_q, rate_d;
  logic                full_q, full_d;

  always_comb begin
    bits_d = bits_q;
    rate_d = rate_q;
    full_d = full_q;
    if (wr_en) begin
      for (int b = 0; b < NB_MAX; b++) begin
        if (wr_beat == CNT_W'(b)) bits_d[b*DATA_W +: DATA_W] = wr_data;
      end
      if (wr_beat == '0) rate_d = wr_rate;
    end
    // A bank is never written and drained in the same cycle, so these never collide.
    if (set_full) full_d = 1'b1;
    if (clr_full) full_d = 1'b0;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      bits_q <= '0;
      rate_q <= '0;
      full_q <= 1'b0;
    end else begin
      bits_q <= bits_d;
      rate_q <= rate_d;
      full_q <= full_d;
    end
  end

  assign bits = bits_q;
  assign rate = rate_q;
  assign full = full_q;

endmodule

// File: rtl/interleaver_stream.sv
// 802.11a/g block (de)interleaver on AXI-Stream: ping-pong banks, one beat per
// cycle each side, permutation realised as fixed per-rate wiring on the read bank.
module interleaver_stream
  import interleaver_stream_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DIRECTION = 0
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [3:0]        s_axis_tuser,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [3:0]        m_axis_tuser,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
);

  localparam int NB_MAX = CBPS_MAX / DATA_W;

  logic                       wsel_q, wsel_d;
  logic                       rsel_q, rsel_d;
  logic [CNT_W-1:0]           wcnt_q, wcnt_d;
  logic [CNT_W-1:0]           rcnt_q, rcnt_d;

  logic [1:0]                 bank_full;
  logic [1:0][3:0]            bank_rate;
  logic [1:0][CBPS_MAX-1:0]   bank_bits;

  logic                       s_hs, m_hs;
  logic                       w_last, r_last, rd_valid;
  logic [3:0]                 w_rate, rd_rate;
  logic [CBPS_MAX-1:0]        rd_bits, perm_sel;
  logic [3:0][CBPS_MAX-1:0]   perm_all;
  logic [DATA_W-1:0]          rd_slice;

  function automatic logic [CNT_W-1:0] last_beat(input logic [3:0] rate);
    case (rate_class(rate))
      CLS_QPSK:  return CNT_W'(CBPS_QPSK / DATA_W - 1);
      CLS_QAM16: return CNT_W'(CBPS_QAM16 / DATA_W - 1);
      CLS_QAM64: return CNT_W'(CBPS_QAM64 / DATA_W - 1);
      default:   return CNT_W'(CBPS_BPSK / DATA_W - 1);
    endcase
  endfunction

  assign s_axis_tready = ~bank_full[wsel_q] & ~areset;
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  // Beat 0 has no stored rate yet, so the block length comes straight from tuser.
  assign w_rate        = (wcnt_q == '0) ? s_axis_tuser : bank_rate[wsel_q];
  assign w_last        = (wcnt_q == last_beat(w_rate));

  assign rd_valid = bank_full[rsel_q];
  assign rd_rate  = bank_rate[rsel_q];
  assign rd_bits  = bank_bits[rsel_q];
  assign r_last   = (rcnt_q == last_beat(rd_rate));
  assign m_hs     = rd_valid & m_axis_tready;

  always_comb begin
    wsel_d = wsel_q;
    wcnt_d = wcnt_q;
    rsel_d = rsel_q;
    rcnt_d = rcnt_q;
    if (s_hs) begin
      if (w_last) begin
        wcnt_d = '0;
        wsel_d = ~wsel_q;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
    if (m_hs) begin
      if (r_last) begin
        rcnt_d = '0;
        rsel_d = ~rsel_q;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wsel_q <= 1'b0;
      rsel_q <= 1'b0;
      wcnt_q <= '0;
      rcnt_q <= '0;
    end else begin
      wsel_q <= wsel_d;
      rsel_q <= rsel_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
    end
  end

  genvar gi, ci;

  for (gi = 0; gi < 2; gi++) begin : g_bank
    interleaver_bank #(
      .DATA_W (DATA_W)
    ) u_bank (
      .aclk     (aclk),
      .areset   (areset),
      .wr_en    (s_hs && (wsel_q == 1'(gi))),
      .wr_beat  (wcnt_q),
      .wr_data  (s_axis_tdata),
      .wr_rate  (s_axis_tuser),
      .set_full (s_hs && w_last && (wsel_q == 1'(gi))),
      .clr_full (m_hs && r_last && (rsel_q == 1'(gi))),
      .bits     (bank_bits[gi]),
      .rate     (bank_rate[gi]),
      .full     (bank_full[gi])
    );
  end

  // Output bit x of each rate class is a fixed tap of the read bank.
  for (ci = 0; ci < 4; ci++) begin : g_cls
    localparam int N = cbps_of_class(ci);
    for (gi = 0; gi < CBPS_MAX; gi++) begin : g_bit
      if (gi < N) begin : g_map
        localparam int SRC = (DIRECTION != 0) ? perm_fwd(gi, N) : perm_inv(gi, N);
        assign perm_all[ci][gi] = rd_bits[SRC];
      end else begin : g_pad
        assign perm_all[ci][gi] = 1'b0;
      end
    end
  end

  assign perm_sel = perm_all[rate_class(rd_rate)];

  always_comb begin
    rd_slice = '0;
    for (int b = 0; b < NB_MAX; b++) begin
      if (rcnt_q == CNT_W'(b)) rd_slice = perm_sel[b*DATA_W +: DATA_W];
    end
  end

  assign m_axis_tvalid = rd_valid;
  assign m_axis_tdata  = rd_valid ? rd_slice : '0;
  assign m_axis_tuser  = rd_valid ? rd_rate : 4'd0;
  assign m_axis_tlast  = rd_valid & r_last;

endmodule

// File: tb/tb_interleaver_stream.sv
// Directed bench: single-bit permutation vectors, back-pressure, streaming,
// mixed rates, mid-block reset and a forward-into-inverse round trip.
module tb_interleaver_stream;

  localparam int DW = 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [3:0]    s_tuser = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic [3:0]    m_tuser;
  logic          m_tlast, m_tvalid;
  logic          tb_tready = 1'b1;
  logic          chain = 1'b0;
  logic          tx_m_tready;
  logic          rx_s_tready, rx_s_tvalid;
  logic [DW-1:0] rx_m_tdata;
  logic [3:0]    rx_m_tuser;
  logic          rx_m_tlast, rx_m_tvalid;
  logic          rx_m_tready = 1'b1;

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;

  int            in_cyc[$];
  logic [DW-1:0] out_data[$];
  logic [3:0]    out_user[$];
  logic          out_last[$];
  int            out_cyc[$];
  logic [DW-1:0] rx_data[$];
  logic [3:0]    rx_user[$];

  assign tx_m_tready = chain ? rx_s_tready : tb_tready;
  assign rx_s_tvalid = chain & m_tvalid;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  interleaver_stream #(.DATA_W(DW), .DIRECTION(0)) u_tx (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_tdata),
    .s_axis_tuser  (s_tuser),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tuser  (m_tuser),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (tx_m_tready)
  );

  interleaver_stream #(.DATA_W(DW), .DIRECTION(1)) u_rx (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (m_tdata),
    .s_axis_tuser  (m_tuser),
    .s_axis_tvalid (rx_s_tvalid),
    .s_axis_tready (rx_s_tready),
    .m_axis_tdata  (rx_m_tdata),
    .m_axis_tuser  (rx_m_tuser),
    .m_axis_tlast  (rx_m_tlast),
    .m_axis_tvalid (rx_m_tvalid),
    .m_axis_tready (rx_m_tready)
  );

  // Handshakes seen at the falling edge complete at the following rising edge.
  always @(negedge aclk) begin
    if (!areset) begin
      if (s_tvalid && s_tready) in_cyc.push_back(cyc);
      if (m_tvalid && tx_m_tready) begin
        out_data.push_back(m_tdata);
        out_user.push_back(m_tuser);
        out_last.push_back(m_tlast);
        out_cyc.push_back(cyc);
      end
      if (rx_m_tvalid && rx_m_tready) begin
        rx_data.push_back(rx_m_tdata);
        rx_user.push_back(rx_m_tuser);
      end
    end
  end

  task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clear_logs();
    in_cyc.delete();
    out_data.delete();
    out_user.delete();
    out_last.delete();
    out_cyc.delete();
    rx_data.delete();
    rx_user.delete();
  endtask

  // Beats after the first carry a wrong tuser on purpose; only beat 0 may count.
  task automatic send_block(input logic [3:0] rate, input logic [287:0] bits, input int nb);
    for (int b = 0; b < nb; b++) begin
      int budget;
      budget   = 0;
      s_tvalid = 1'b1;
      s_tdata  = bits[b*DW +: DW];
      s_tuser  = (b == 0) ? rate : ~rate;
      @(negedge aclk);
      while (!s_tready && budget < 300) begin
        budget++;
        @(negedge aclk);
      end
      if (!s_tready) begin
        check("send_timeout", 288'(b), 288'(nb));
        s_tvalid = 1'b0;
        @(posedge aclk); #1;
        return;
      end
      @(posedge aclk); #1;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int n);
    int budget;
    budget = 0;
    while (out_data.size() < n && budget < 2000) begin
      @(posedge aclk); #1;
      budget++;
    end
    check(tag, 288'(out_data.size()), 288'(n));
  endtask

  function automatic logic [287:0] out_bits(input int start, input int nb);
    logic [287:0] v;
    v = '0;
    for (int b = 0; b < nb; b++) v[b*DW +: DW] = out_data[start+b];
    return v;
  endfunction

  function automatic logic [287:0] rx_bits(input int start, input int nb);
    logic [287:0] v;
    v = '0;
    for (int b = 0; b < nb; b++) v[b*DW +: DW] = rx_data[start+b];
    return v;
  endfunction

  function automatic logic [287:0] last_mask(input int start, input int nb);
    logic [287:0] v;
    v = '0;
    for (int b = 0; b < nb; b++) v[b] = out_last[start+b];
    return v;
  endfunction

  function automatic logic [287:0] rand_bits(input int nb);
    logic [287:0] v;
    for (int w = 0; w < 9; w++) v[w*32 +: 32] = $urandom();
    return v & ((288'h1 << (nb * DW)) - 288'h1);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [287:0] blk;
    logic [287:0] orig [6];
    logic [3:0]   rt_rate [6];
    int           rt_nb [6];
    int           vcount;
    int           base;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_s_tready", 288'(s_tready), 288'd0);
    check("rst_m_tvalid", 288'(m_tvalid), 288'd0);
    check("rst_m_tlast",  288'(m_tlast),  288'd0);
    check("rst_m_tdata",  288'(m_tdata),  288'd0);
    check("rst_m_tuser",  288'(m_tuser),  288'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_s_tready", 288'(s_tready), 288'd1);
    @(posedge aclk); #1;

    // BPSK k=1 -> j=3
    clear_logs();
    send_block(4'hD, 288'h1 << 1, 6);
    wait_out("bpsk_count", 6);
    check("bpsk_data",    out_bits(0, 6), 288'h1 << 3);
    check("bpsk_user",    288'(out_user[0]), 288'hD);
    check("bpsk_last",    last_mask(0, 6), 288'h1 << 5);
    check("bpsk_latency", 288'(out_cyc[0]), 288'(in_cyc[5] + 1));

    // QAM16 k=1 -> j=13
    clear_logs();
    send_block(4'h9, 288'h1 << 1, 24);
    wait_out("qam16_count", 24);
    check("qam16_data", out_bits(0, 24), 288'h1 << 13);
    check("qam16_user", 288'(out_user[23]), 288'h9);
    check("qam16_last", last_mask(0, 24), 288'h1 << 23);

    // QAM64 k=1 -> j=20
    clear_logs();
    send_block(4'h1, 288'h1 << 1, 36);
    wait_out("qam64_count", 36);
    check("qam64_data", out_bits(0, 36), 288'h1 << 20);
    check("qam64_last", last_mask(0, 36), 288'h1 << 35);

    // 6M followed immediately by 48M
    clear_logs();
    send_block(4'hD, 288'h1 << 1, 6);
    send_block(4'h1, 288'h1 << 1, 36);
    wait_out("mixed_count", 42);
    check("mixed_user_b6", 288'(out_user[5]), 288'hD);
    check("mixed_user_b7", 288'(out_user[6]), 288'h1);
    check("mixed_last",    last_mask(0, 42), (288'h1 << 41) | (288'h1 << 5));
    check("mixed_data2",   out_bits(6, 36), 288'h1 << 20);
    check("mixed_in_gap",  288'(in_cyc[41] - in_cyc[0]), 288'd41);

    // Back-pressure with both banks filling
    clear_logs();
    tb_tready = 1'b0;
    s_tvalid  = 1'b1;
    s_tdata   = '0;
    s_tuser   = 4'hD;
    repeat (30) begin @(posedge aclk); #1; end
    check("bp_accepted", 288'(in_cyc.size()), 288'd12);
    @(negedge aclk);
    check("bp_s_tready", 288'(s_tready), 288'd0);
    check("bp_m_tvalid", 288'(m_tvalid), 288'd1);
    @(posedge aclk); #1;
    s_tvalid  = 1'b0;
    tb_tready = 1'b1;
    wait_out("bp_count", 12);
    check("bp_last", last_mask(0, 12), (288'h1 << 11) | (288'h1 << 5));
    check("bp_user", 288'(out_user[11]), 288'hD);

    // Continuous 54M blocks
    clear_logs();
    for (int n = 0; n < 3; n++) send_block(4'h3, rand_bits(36), 36);
    wait_out("stream_count", 108);
    check("stream_in_span",  288'(in_cyc[107] - in_cyc[0]), 288'd107);
    check("stream_first",    288'(out_cyc[0]), 288'(in_cyc[35] + 1));
    check("stream_out_span", 288'(out_cyc[107] - out_cyc[0]), 288'd107);
    check("stream_last",     last_mask(0, 108),
          (288'h1 << 107) | (288'h1 << 71) | (288'h1 << 35));

    // Reset with one buffered block and a partial QAM64 block
    clear_logs();
    tb_tready = 1'b0;
    send_block(4'hD, 288'h1 << 1, 6);
    send_block(4'h3, rand_bits(36), 20);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset    = 1'b0;
    tb_tready = 1'b1;
    vcount    = 0;
    repeat (40) begin
      @(negedge aclk);
      if (m_tvalid) vcount++;
    end
    @(posedge aclk); #1;
    check("rst_mid_tvalid", 288'(vcount), 288'd0);
    check("rst_mid_beats",  288'(out_data.size()), 288'd0);
    send_block(4'hD, 288'h1 << 17, 6);
    wait_out("rst_fresh_count", 6);
    check("rst_fresh_data", out_bits(0, 6), 288'h1 << 4);
    check("rst_fresh_user", 288'(out_user[0]), 288'hD);

    // Interleaver chained into deinterleaver
    clear_logs();
    chain      = 1'b1;
    rt_rate[0] = 4'hD; rt_nb[0] = 6;
    rt_rate[1] = 4'h5; rt_nb[1] = 12;
    rt_rate[2] = 4'h9; rt_nb[2] = 24;
    rt_rate[3] = 4'h1; rt_nb[3] = 36;
    rt_rate[4] = 4'hF; rt_nb[4] = 6;
    rt_rate[5] = 4'hB; rt_nb[5] = 24;
    for (int n = 0; n < 6; n++) begin
      blk     = rand_bits(rt_nb[n]);
      orig[n] = blk;
      send_block(rt_rate[n], blk, rt_nb[n]);
    end
    vcount = 0;
    while (rx_data.size() < 108 && vcount < 2000) begin
      @(posedge aclk); #1;
      vcount++;
    end
    check("rt_count", 288'(rx_data.size()), 288'd108);
    base = 0;
    for (int n = 0; n < 6; n++) begin
      check($sformatf("rt_data_%0d", n), rx_bits(base, rt_nb[n]), orig[n]);
      check($sformatf("rt_user_%0d", n), 288'(rx_user[base]), 288'(rt_rate[n]));
      base += rt_nb[n];
    end
    chain = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
